// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and types for the sequential Booth multiplier.
//   WIDTH       operand width; hi/lo are each WIDTH bits
//   STEPS       Booth iterations on the extended (WIDTH+1)-bit multiplier
//   CNT_W       width of the step counter
//   state_e     FSM states IDLE, RUN, DONE
//   booth_op_e  radix-2 Booth recode result: NOP, ADD, SUB
package mult_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEPS = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        ADD = 2'b01,
        SUB = 2'b10
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}.
    function automatic booth_op_e booth_recode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_booth_step.sv
// mult_booth_step: one combinational radix-2 Booth iteration.
// Adds or subtracts the multiplicand according to {Q[0], q_1}, then
// arithmetic-shifts {acc, Q, q_1} right by one.
//   i_acc  [WIDTH+1:0]  partial-product accumulator
//   i_q    [WIDTH:0]    extended multiplier / low product bits
//   i_q_1               previously shifted-out multiplier bit
//   i_m    [WIDTH+1:0]  extended multiplicand
//   o_acc, o_q, o_q_1   values after the step
module mult_booth_step
    import mult_pkg::*;
(
    input  logic [WIDTH+1:0] i_acc,
    input  logic [WIDTH:0]   i_q,
    input  logic             i_q_1,
    input  logic [WIDTH+1:0] i_m,
    output logic [WIDTH+1:0] o_acc,
    output logic [WIDTH:0]   o_q,
    output logic             o_q_1
);

    logic [WIDTH+1:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case (booth_recode(i_q[0], i_q_1))
            ADD:     w_sum = i_acc + i_m;
            SUB:     w_sum = i_acc - i_m;
            default: w_sum = i_acc;
        endcase
    end

    // Arithmetic shift of the concatenation {sum, Q, q_1}.
    assign o_acc = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH:1]};
    assign o_q_1 = i_q[0];

endmodule

// File: rtl/mult_booth.sv
// mult_booth: sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// MultSig samples the operands; STEPS Booth steps follow, then hi/lo are
// written and flag pulses for one cycle. MultSig in any state restarts.
//   clock        single clock, rising edge
//   reset        synchronous, active low
//   MultSig      start strobe
//   is_unsigned  only with MULT_UNSIGNED_EN defined: 1 = zero-extend operands
//   a, b         multiplicand, multiplier
//   hi, lo       upper / lower halves of the product
//   flag         one-cycle done pulse
// Optional build macro: MULT_UNSIGNED_EN (adds is_unsigned / multu support).
module mult_booth
    import mult_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             MultSig,
`ifdef MULT_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             flag
);

    state_e           r_state, w_state_next;
    logic [WIDTH+1:0] r_m,     w_m_next;
    logic [WIDTH+1:0] r_acc,   w_acc_next;
    logic [WIDTH:0]   r_q,     w_q_next;
    logic             r_q_1,   w_q_1_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [WIDTH-1:0] r_hi,    w_hi_next;
    logic [WIDTH-1:0] r_lo,    w_lo_next;
    logic             r_flag,  w_flag_next;

    logic             w_ext_a;
    logic             w_ext_b;
    logic [WIDTH+1:0] w_step_acc;
    logic [WIDTH:0]   w_step_q;
    logic             w_step_q_1;
    logic [2:0]       w_unused_acc;

`ifdef MULT_UNSIGNED_EN
    assign w_ext_a = is_unsigned ? 1'b0 : a[WIDTH-1];
    assign w_ext_b = is_unsigned ? 1'b0 : b[WIDTH-1];
`else
    assign w_ext_a = a[WIDTH-1];
    assign w_ext_b = b[WIDTH-1];
`endif

    mult_booth_step u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_acc (w_step_acc),
        .o_q   (w_step_q),
        .o_q_1 (w_step_q_1)
    );

    // The top accumulator bits are only sign copies once all steps are done.
    assign w_unused_acc = r_acc[WIDTH+1:WIDTH-1];

    always_comb begin
        w_state_next = r_state;
        w_m_next     = r_m;
        w_acc_next   = r_acc;
        w_q_next     = r_q;
        w_q_1_next   = r_q_1;
        w_count_next = r_count;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_flag_next  = 1'b0;

        if (MultSig) begin
            // Start or restart from any state; a pending result is dropped.
            w_m_next     = {{2{w_ext_a}}, a};
            w_q_next     = {w_ext_b, b};
            w_acc_next   = '0;
            w_q_1_next   = 1'b0;
            w_count_next = CNT_W'(STEPS);
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    w_acc_next   = w_step_acc;
                    w_q_next     = w_step_q;
                    w_q_1_next   = w_step_q_1;
                    w_count_next = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    // Low 2*WIDTH bits of {acc, Q}.
                    w_hi_next    = {r_acc[WIDTH-2:0], r_q[WIDTH]};
                    w_lo_next    = r_q[WIDTH-1:0];
                    w_flag_next  = 1'b1;
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q_1   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_m     <= w_m_next;
            r_acc   <= w_acc_next;
            r_q     <= w_q_next;
            r_q_1   <= w_q_1_next;
            r_count <= w_count_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_flag  <= w_flag_next;
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign flag = r_flag;

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: directed, table-driven bench for mult_booth.
// Covers reset values, signed products and corner operands, latency,
// restart mid-operation, reset mid-operation, and (with MULT_UNSIGNED_EN)
// unsigned products.
module tb_mult_booth;

    logic        clock;
    logic        reset;
    logic        MultSig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        flag;
`ifdef MULT_UNSIGNED_EN
    logic        is_unsigned;
`endif

    int n_checks;
    int n_fail;

    mult_booth dut (
        .clock       (clock),
        .reset       (reset),
        .MultSig     (MultSig),
`ifdef MULT_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .flag        (flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Present operands so that the next posedge (E0) samples MultSig=1.
    task automatic start(input logic [31:0] ta, input logic [31:0] tb);
        @(negedge clock);
        a       = ta;
        b       = tb;
        MultSig = 1'b1;
        @(posedge clock);
        #1;
        MultSig = 1'b0;
    endtask

    // Count edges after E0 until flag appears; lat = -1 if it never does.
    task automatic wait_flag(input logic [63:0] prior, output int lat, output bit held);
        lat  = -1;
        held = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (flag) begin
                lat = i;
                break;
            end
            if ({hi, lo} !== prior) held = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        bit          held;
        logic [63:0] prior;

        n_checks = 0;
        n_fail   = 0;
        MultSig  = 1'b0;
        a        = '0;
        b        = '0;
        reset    = 1'b0;
`ifdef MULT_UNSIGNED_EN
        is_unsigned = 1'b0;
`endif

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[7] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};
        vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9] = '{32'h1234_5678, 32'h0000_0002, 64'h0000_0000_2468_ACF0};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_flag", {63'd0, flag}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Table of signed products.
        prior = 64'd0;
        for (int i = 0; i < NVEC; i++) begin
            start(vecs[i].a, vecs[i].b);
            wait_flag(prior, lat, held);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("vec%0d_hold", i), {63'd0, held}, 64'd1);
            check($sformatf("vec%0d_product", i), {hi, lo}, vecs[i].p);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_flag_one_cycle", i), {63'd0, flag}, 64'd0);
            prior = vecs[i].p;
        end

        // Restart: 3x5, then 2x2 at cycle 10; only the second result appears.
        start(32'd3, 32'd5);
        held = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clock);
            #1;
            if (flag || ({hi, lo} !== prior)) held = 1'b0;
        end
        check("restart_pre_hold", {63'd0, held}, 64'd1);
        start(32'd2, 32'd2);
        wait_flag(prior, lat, held);
        check("restart_latency", 64'(lat), 64'd34);
        check("restart_hold", {63'd0, held}, 64'd1);
        check("restart_product", {hi, lo}, 64'd4);
        prior = 64'd4;

        // Reset at cycle 5 of a 3x5 aborts it and zeroes hi/lo.
        start(32'd3, 32'd5);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        check("midreset_hi_lo", {hi, lo}, 64'd0);
        check("midreset_flag", {63'd0, flag}, 64'd0);
        wait_flag(64'd0, lat, held);
        check("midreset_no_flag", {63'd0, lat != -1}, 64'd0);
        check("midreset_hold_zero", {63'd0, held}, 64'd1);
        start(32'd4, 32'd4);
        wait_flag(64'd0, lat, held);
        check("post_reset_latency", 64'(lat), 64'd34);
        check("post_reset_product", {hi, lo}, 64'd16);

`ifdef MULT_UNSIGNED_EN
        @(negedge clock);
        is_unsigned = 1'b1;
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_flag(64'd16, lat, held);
        check("multu_latency", 64'(lat), 64'd34);
        check("multu_product", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clock);
        is_unsigned = 1'b0;
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_flag(64'hFFFF_FFFE_0000_0001, lat, held);
        check("mult_latency", 64'(lat), 64'd34);
        check("mult_product", {hi, lo}, 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
